// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 constants and receive-frame state encoding, reused by
// the game input blocks.
package ps2_pkg;

    // Set-2 prefix bytes
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // Set-2 make codes used by the benchmark games
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_1     = 8'h16;
    localparam logic [7:0] KEY_2     = 8'h1E;
    localparam logic [7:0] KEY_ENTER = 8'h5A;

    // Position inside an 11-bit PS/2 frame (start, 8 data, parity, stop)
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_frame_state_e;

    // Odd parity holds when data plus parity bit contain an odd number of ones
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receive framer: synchronises the raw keyboard lines, detects falling
// clock edges, deserialises 11-bit frames and aborts stalled frames. Emits the
// byte of each good frame with a one-cycle valid pulse, or a one-cycle error.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       ps2_clk_sync_q;   // [0],[1] synchroniser, [2] previous value
    logic [1:0]       ps2_dat_sync_q;
    ps2_frame_state_e state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             parity_q, parity_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic fall_edge;
    logic dat_bit;
    logic timeout;

    assign fall_edge = ps2_clk_sync_q[2] & ~ps2_clk_sync_q[1];
    assign dat_bit   = ps2_dat_sync_q[1];
    assign timeout   = (state_q != ST_IDLE) && !fall_edge && (tmo_cnt_q == TMO_LAST);

    // Two-flop synchronisers plus edge-history flop; idle bus level is high,
    // so reset to 1 to avoid a phantom edge when reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2_clk_sync_q <= 3'b111;
            ps2_dat_sync_q <= 2'b11;
        end else begin
            // NOTE: flops use non-blocking assignments so every register samples
            // the pre-edge value of its neighbours, exactly like the hardware.
            ps2_clk_sync_q <= {ps2_clk_sync_q[1:0], ps2_clk_i};
            ps2_dat_sync_q <= {ps2_dat_sync_q[0], ps2_dat_i};
        end
    end

    // Frame state, shift register, timeout counter and output pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tmo_cnt_q <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tmo_cnt_q <= tmo_cnt_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: advance one frame bit per synchronised falling edge
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        tmo_cnt_d = (state_q == ST_IDLE || fall_edge) ? '0 : tmo_cnt_q + TMO_W'(1);

        if (timeout) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else if (fall_edge) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!dat_bit) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    parity_d = dat_bit;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (dat_bit && ps2_parity_ok(shift_q, parity_q)) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end for the reaction-time game: tracks F0/E0 prefixes
// and held keys on top of the frame receiver, giving one make pulse per
// physical press of SPACE or '1' regardless of typematic repeat.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  SPACE_CODE     = KEY_SPACE,
    parameter logic [7:0]  ONE_CODE       = KEY_1
) (
    input  logic       clk,
    input  logic       iReset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       spacePressed,
    output logic       onePressed,
    output logic [7:0] oScanCode,
    output logic       oScanValid,
    output logic       oFrameError
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    logic brk_q, brk_d;
    logic ext_q, ext_d;
    logic space_held_q, space_held_d;
    logic one_held_q, one_held_d;
    logic space_pulse;
    logic one_pulse;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk          (clk),
        .rst_n        (iReset),
        .ps2_clk_i    (PS2_CLK),
        .ps2_dat_i    (PS2_DAT),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_err)
    );

    // Prefix and held-key flags
    always_ff @(posedge clk or negedge iReset) begin
        if (!iReset) begin
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            space_held_q <= 1'b0;
            one_held_q   <= 1'b0;
        end else begin
            brk_q        <= brk_d;
            ext_q        <= ext_d;
            space_held_q <= space_held_d;
            one_held_q   <= one_held_d;
        end
    end

    // Byte interpretation; pulses are combinational off the registered rx
    // valid so they line up with oScanValid in the same cycle.
    always_comb begin
        brk_d        = brk_q;
        ext_d        = ext_q;
        space_held_d = space_held_q;
        one_held_d   = one_held_q;
        space_pulse  = 1'b0;
        one_pulse    = 1'b0;

        if (rx_valid) begin
            if (rx_byte == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_BREAK) begin
                brk_d = 1'b1;
            end else begin
                // Extended codes share values with SPACE/'1' but are other keys
                if (!ext_q) begin
                    if (rx_byte == SPACE_CODE) begin
                        if (brk_q) begin
                            space_held_d = 1'b0;
                        end else begin
                            space_pulse  = !space_held_q;
                            space_held_d = 1'b1;
                        end
                    end
                    if (rx_byte == ONE_CODE) begin
                        if (brk_q) begin
                            one_held_d = 1'b0;
                        end else begin
                            one_pulse  = !one_held_q;
                            one_held_d = 1'b1;
                        end
                    end
                end
                brk_d = 1'b0;
                ext_d = 1'b0;
            end
        end else if (rx_err) begin
            // A lost frame may have carried part of a prefix sequence
            brk_d = 1'b0;
            ext_d = 1'b0;
        end
    end

    assign spacePressed = space_pulse;
    assign onePressed   = one_pulse;
    assign oScanCode    = rx_byte;
    assign oScanValid   = rx_valid;
    assign oFrameError  = rx_err;

endmodule
